// File: rtl/mem_stage.sv
// MIPS MEM stage: sized load/store on a req/ack bus with alignment check,
// bus timeout, pipeline stall control and the MEM/WB pipeline register.
module mem_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] EX_MEM_alu_result,
   input  logic [31:0] EX_MEM_B_value,
   input  logic [4:0]  EX_MEM_dst_reg,
   input  logic [5:0]  EX_MEM_opcode,
   input  logic        EX_MEM_mem_read,
   input  logic        EX_MEM_mem_write,
   input  logic        EX_MEM_wb_reg_write,
   input  logic        EX_MEM_wb_mem_to_reg,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   output logic        pstop_o,
   output logic [31:0] mem_fwd_val,
   output logic        align_err_o,
   output logic        bus_err_o,
   output logic [31:0] MEM_WB_alu_result,
   output logic [31:0] MEM_WB_mem_data,
   output logic [4:0]  MEM_WB_dst_reg,
   output logic        MEM_WB_wb_reg_write,
   output logic        MEM_WB_wb_mem_to_reg
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam bit             TO_EN   = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_req;
   logic             r_we;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_be;
   logic [1:0]       r_size;
   logic             r_sign;
   logic [1:0]       r_off;
   logic             r_bus_err;
   logic [31:0]      r_wb_alu;
   logic [31:0]      r_wb_data;
   logic [4:0]       r_wb_dst;
   logic             r_wb_rw;
   logic             r_wb_m2r;

   logic             w_access;
   logic [1:0]       w_size;
   logic             w_sign;
   logic             w_misal;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic             w_start;
   logic             w_align_err;
   logic             w_timeout;
   logic             w_wait;

   // Selects the addressed byte/half of a returned word and extends it.
   function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] sz,
                                            input logic sgn, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (off)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = off[1] ? d[31:16] : d[15:0];
      case (sz)
         SZ_B:    res = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
         SZ_H:    res = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
         default: res = d;
      endcase
      return res;
   endfunction

   assign w_access = EX_MEM_mem_read | EX_MEM_mem_write;

   // Opcode decode: access size and signedness.
   always_comb begin
      w_size = SZ_W;
      w_sign = 1'b0;
      case (EX_MEM_opcode)
         6'h20:        begin w_size = SZ_B; w_sign = 1'b1; end
         6'h24, 6'h28: begin w_size = SZ_B; w_sign = 1'b0; end
         6'h21:        begin w_size = SZ_H; w_sign = 1'b1; end
         6'h25, 6'h29: begin w_size = SZ_H; w_sign = 1'b0; end
         default:      begin w_size = SZ_W; w_sign = 1'b0; end
      endcase
   end

   // Alignment check, byte enables and lane-replicated store data.
   always_comb begin
      w_misal = 1'b0;
      w_be    = 4'b1111;
      w_wdata = EX_MEM_B_value;
      case (w_size)
         SZ_B: begin
            w_misal = 1'b0;
            w_be    = 4'b0001 << EX_MEM_alu_result[1:0];
            w_wdata = {4{EX_MEM_B_value[7:0]}};
         end
         SZ_H: begin
            w_misal = EX_MEM_alu_result[0];
            w_be    = EX_MEM_alu_result[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{EX_MEM_B_value[15:0]}};
         end
         default: begin
            w_misal = (EX_MEM_alu_result[1:0] != 2'b00);
            w_be    = 4'b1111;
            w_wdata = EX_MEM_B_value;
         end
      endcase
      if (EX_MEM_mem_read) begin
         w_wdata = 32'h0000_0000;
      end else begin
         w_wdata = w_wdata;
      end
   end

   assign w_start     = (r_state == S_IDLE) & w_access & ~w_misal;
   assign w_align_err = (r_state == S_IDLE) & w_access & w_misal;
   assign w_timeout   = (r_state == S_BUSY) & ~bus_ack_i & TO_EN & (r_cnt == TO_LAST);
   assign w_wait      = (r_state == S_BUSY) & ~bus_ack_i & ~w_timeout;

   // Stall and alignment pulse are forced low while reset is asserted.
   assign pstop_o     = rst & (w_start | w_wait);
   assign align_err_o = rst & w_align_err;
   assign mem_fwd_val = EX_MEM_alu_result;

   // Access FSM, bus request registers and MEM/WB pipeline register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= 32'h0000_0000;
         r_wdata   <= 32'h0000_0000;
         r_be      <= 4'b0000;
         r_size    <= SZ_W;
         r_sign    <= 1'b0;
         r_off     <= 2'b00;
         r_bus_err <= 1'b0;
         r_wb_alu  <= 32'h0000_0000;
         r_wb_data <= 32'h0000_0000;
         r_wb_dst  <= 5'd0;
         r_wb_rw   <= 1'b0;
         r_wb_m2r  <= 1'b0;
      end else begin
         r_bus_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_BUSY;
                  r_cnt   <= '0;
                  r_req   <= 1'b1;
                  r_we    <= ~EX_MEM_mem_read;
                  r_addr  <= {EX_MEM_alu_result[31:2], 2'b00};
                  r_wdata <= w_wdata;
                  r_be    <= w_be;
                  r_size  <= w_size;
                  r_sign  <= w_sign;
                  r_off   <= EX_MEM_alu_result[1:0];
                  r_wb_rw <= 1'b0;
               end else begin
                  r_wb_alu  <= EX_MEM_alu_result;
                  r_wb_data <= 32'h0000_0000;
                  r_wb_dst  <= EX_MEM_dst_reg;
                  r_wb_rw   <= EX_MEM_wb_reg_write & ~w_align_err;
                  r_wb_m2r  <= EX_MEM_wb_mem_to_reg;
               end
            end
            S_BUSY: begin
               if (bus_ack_i) begin
                  r_state   <= S_IDLE;
                  r_req     <= 1'b0;
                  r_wb_alu  <= EX_MEM_alu_result;
                  r_wb_data <= r_we ? 32'h0000_0000 : fmt_load(bus_rdata_i, r_size, r_sign, r_off);
                  r_wb_dst  <= EX_MEM_dst_reg;
                  r_wb_rw   <= EX_MEM_wb_reg_write;
                  r_wb_m2r  <= EX_MEM_wb_mem_to_reg;
               end else if (w_timeout) begin
                  r_state   <= S_IDLE;
                  r_req     <= 1'b0;
                  r_bus_err <= 1'b1;
                  r_wb_alu  <= EX_MEM_alu_result;
                  r_wb_data <= 32'h0000_0000;
                  r_wb_dst  <= EX_MEM_dst_reg;
                  r_wb_rw   <= 1'b0;
                  r_wb_m2r  <= EX_MEM_wb_mem_to_reg;
               end else begin
                  r_cnt   <= r_cnt + CNT_ONE;
                  r_wb_rw <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign bus_req_o            = r_req;
   assign bus_we_o             = r_we;
   assign bus_addr_o           = r_addr;
   assign bus_wdata_o          = r_wdata;
   assign bus_be_o             = r_be;
   assign bus_err_o            = r_bus_err;
   assign MEM_WB_alu_result    = r_wb_alu;
   assign MEM_WB_mem_data      = r_wb_data;
   assign MEM_WB_dst_reg       = r_wb_dst;
   assign MEM_WB_wb_reg_write  = r_wb_rw;
   assign MEM_WB_wb_mem_to_reg = r_wb_m2r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage against an arithmetic model of
// sizing, lanes, alignment and bus timing.
module tb_mem_stage;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] alu = 32'h0;
   logic [31:0] bval = 32'h0;
   logic [4:0]  dst = 5'd0;
   logic [5:0]  opc = 6'h0;
   logic        mrd = 1'b0;
   logic        mwr = 1'b0;
   logic        wrw = 1'b0;
   logic        wm2r = 1'b0;
   logic        ack = 1'b0;
   logic [31:0] rdata = 32'h0;

   logic        bus_req_o, bus_we_o, pstop_o, align_err_o, bus_err_o;
   logic [31:0] bus_addr_o, bus_wdata_o, mem_fwd_val;
   logic [3:0]  bus_be_o;
   logic [31:0] MEM_WB_alu_result, MEM_WB_mem_data;
   logic [4:0]  MEM_WB_dst_reg;
   logic        MEM_WB_wb_reg_write, MEM_WB_wb_mem_to_reg;

   int errors = 0;
   int checks = 0;

   mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .EX_MEM_alu_result(alu), .EX_MEM_B_value(bval), .EX_MEM_dst_reg(dst),
      .EX_MEM_opcode(opc), .EX_MEM_mem_read(mrd), .EX_MEM_mem_write(mwr),
      .EX_MEM_wb_reg_write(wrw), .EX_MEM_wb_mem_to_reg(wm2r),
      .bus_ack_i(ack), .bus_rdata_i(rdata),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .pstop_o(pstop_o),
      .mem_fwd_val(mem_fwd_val), .align_err_o(align_err_o), .bus_err_o(bus_err_o),
      .MEM_WB_alu_result(MEM_WB_alu_result), .MEM_WB_mem_data(MEM_WB_mem_data),
      .MEM_WB_dst_reg(MEM_WB_dst_reg), .MEM_WB_wb_reg_write(MEM_WB_wb_reg_write),
      .MEM_WB_wb_mem_to_reg(MEM_WB_wb_mem_to_reg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [5:0] op);
      if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 1;
      if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] d);
      int nb = nbytes(op);
      logic [31:0] mask;
      logic [31:0] v;
      if (nb == 4) return d;
      mask = (32'd1 << (8 * nb)) - 32'd1;
      v = (d >> (8 * int'(a % 4))) & mask;
      if ((op == 6'h20 || op == 6'h21) && v >= (32'd1 << (8 * nb - 1))) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] b);
      int nb = nbytes(op);
      logic [31:0] w = 32'h0;
      for (int i = 0; i < 4; i++) w = w | (((b >> (8 * (i % nb))) & 32'hFF) << (8 * i));
      return w;
   endfunction

   // One EX/MEM instruction; called 1 time unit after a rising edge.
   // ack_delay = BUSY cycle index carrying ack; negative means never.
   task automatic access(input logic [5:0] op, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                         input logic rw, input logic m2r, input int ack_delay,
                         input logic [31:0] rdv);
      int  nb, nbusy, reqc, pstc;
      bit  acked, mis;
      opc = op; mrd = rd; mwr = wr; alu = a; bval = b; dst = d; wrw = rw; wm2r = m2r;
      nb    = nbytes(op);
      mis   = (a % nb) != 0;
      acked = (ack_delay >= 0) && (ack_delay < TIMEOUT);
      nbusy = acked ? ack_delay + 1 : TIMEOUT;
      @(negedge clk);
      chk("fwd", mem_fwd_val, a);
      if (!rd && !wr) begin
         chk("nop_pstop", 32'(pstop_o), 32'd0);
         @(posedge clk); #1;
         chk("nop_alu", MEM_WB_alu_result, a);
         chk("nop_dst", 32'(MEM_WB_dst_reg), 32'(d));
         chk("nop_rw", 32'(MEM_WB_wb_reg_write), 32'(rw));
         chk("nop_m2r", 32'(MEM_WB_wb_mem_to_reg), 32'(m2r));
         chk("nop_data", MEM_WB_mem_data, 32'd0);
      end else if (mis) begin
         chk("mis_align", 32'(align_err_o), 32'd1);
         chk("mis_pstop", 32'(pstop_o), 32'd0);
         @(posedge clk); #1;
         chk("mis_req", 32'(bus_req_o), 32'd0);
         chk("mis_rw", 32'(MEM_WB_wb_reg_write), 32'd0);
         chk("mis_data", MEM_WB_mem_data, 32'd0);
         chk("mis_dst", 32'(MEM_WB_dst_reg), 32'(d));
         mrd = 1'b0; mwr = 1'b0;
         @(negedge clk);
         chk("mis_pulse_end", 32'(align_err_o), 32'd0);
         @(posedge clk); #1;
      end else begin
         chk("acc_align", 32'(align_err_o), 32'd0);
         chk("acc_req0", 32'(bus_req_o), 32'd0);
         pstc = int'(pstop_o);
         reqc = 0;
         @(posedge clk); #1;
         for (int k = 0; k < nbusy; k++) begin
            if (acked && k == ack_delay) begin
               ack = 1'b1; rdata = rdv;
            end else begin
               ack = 1'b0; rdata = $urandom;
            end
            @(negedge clk);
            reqc += int'(bus_req_o);
            pstc += int'(pstop_o);
            if (k == 0) begin
               chk("bus_addr", bus_addr_o, a & 32'hFFFF_FFFC);
               chk("bus_we", 32'(bus_we_o), 32'(!rd));
               chk("bubble_rw", 32'(MEM_WB_wb_reg_write), 32'd0);
               if (!rd) begin
                  chk("bus_be", 32'(bus_be_o), ((32'd1 << nb) - 32'd1) << (a % 4));
                  chk("bus_wdata", bus_wdata_o, m_wdata(op, b));
               end
            end
            @(posedge clk); #1;
         end
         ack = 1'b0;
         mrd = 1'b0; mwr = 1'b0;
         chk("req_cycles", 32'(reqc), 32'(nbusy));
         chk("pstop_cycles", 32'(pstc), 32'(nbusy));
         chk("req_drop", 32'(bus_req_o), 32'd0);
         chk("bus_err", 32'(bus_err_o), 32'(!acked));
         chk("wb_rw", 32'(MEM_WB_wb_reg_write), acked ? 32'(rw) : 32'd0);
         chk("wb_data", MEM_WB_mem_data, (acked && rd) ? m_load(op, a, rdv) : 32'd0);
         chk("wb_dst", 32'(MEM_WB_dst_reg), 32'(d));
         chk("wb_alu", MEM_WB_alu_result, a);
         @(posedge clk); #1;
         chk("bus_err_end", 32'(bus_err_o), 32'd0);
      end
   endtask

   logic [5:0] ops [9];
   logic [5:0] op;
   logic       rd;

   initial begin
      ops = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h0F};
      #2;
      chk("rst_req", 32'(bus_req_o), 32'd0);
      chk("rst_be", 32'(bus_be_o), 32'd0);
      chk("rst_wb_rw", 32'(MEM_WB_wb_reg_write), 32'd0);
      chk("rst_pstop", 32'(pstop_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      access(6'h23, 1'b1, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1, 1'b1, 2, 32'hDEADBEEF);
      access(6'h20, 1'b1, 1'b0, 32'h103, 32'h0, 5'd4, 1'b1, 1'b1, 0, 32'h80123456);
      access(6'h24, 1'b1, 1'b0, 32'h103, 32'h0, 5'd5, 1'b1, 1'b1, 1, 32'h80123456);
      access(6'h25, 1'b1, 1'b0, 32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 0, 32'h80123456);
      access(6'h29, 1'b0, 1'b1, 32'h206, 32'h1234ABCD, 5'd0, 1'b0, 1'b0, 2, 32'h0);
      access(6'h23, 1'b1, 1'b0, 32'h101, 32'h0, 5'd7, 1'b1, 1'b1, 0, 32'h0);
      access(6'h00, 1'b0, 1'b0, 32'h5555, 32'h0, 5'd8, 1'b1, 1'b0, 0, 32'h0);
      access(6'h23, 1'b1, 1'b0, 32'h300, 32'h0, 5'd9, 1'b1, 1'b1, -1, 32'h0);
      access(6'h23, 1'b1, 1'b0, 32'h304, 32'h0, 5'd10, 1'b1, 1'b1, 15, 32'hCAFEF00D);
      access(6'h21, 1'b1, 1'b1, 32'h402, 32'h0, 5'd11, 1'b1, 1'b1, 0, 32'h9ABC0000);

      // Ack while idle must be ignored
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      chk("idle_ack_req", 32'(bus_req_o), 32'd0);

      // Randomized accesses and no-access instructions
      for (int n = 0; n < 40; n++) begin
         op = ops[$urandom_range(0, 8)];
         rd = (op == 6'h0F) ? 1'($urandom_range(0, 1)) : (op < 6'h28);
         if ($urandom_range(0, 4) == 0)
            access(op, 1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 0, 32'h0);
         else
            access(op, rd, !rd, 32'h1000 + 32'($urandom_range(0, 255)), $urandom, 5'($urandom),
                   1'($urandom), 1'($urandom), $urandom_range(0, 5), $urandom);
      end

      // Reset asserted mid-BUSY, then a late ack
      access(6'h00, 1'b0, 1'b0, 32'h77, 32'h0, 5'd12, 1'b1, 1'b1, 0, 32'h0);
      opc = 6'h23; mrd = 1'b1; mwr = 1'b0; alu = 32'h500; dst = 5'd13; wrw = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_req", 32'(bus_req_o), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_req", 32'(bus_req_o), 32'd0);
      chk("mid_rst_pstop", 32'(pstop_o), 32'd0);
      chk("mid_rst_we", 32'(bus_we_o), 32'd0);
      chk("mid_rst_wb_alu", MEM_WB_alu_result, 32'd0);
      chk("mid_rst_wb_dst", 32'(MEM_WB_dst_reg), 32'd0);
      chk("mid_rst_wb_rw", 32'(MEM_WB_wb_reg_write), 32'd0);
      chk("mid_rst_wb_m2r", 32'(MEM_WB_wb_mem_to_reg), 32'd0);
      mrd = 1'b0; wrw = 1'b0;
      #1 rst = 1'b1;
      ack = 1'b1; rdata = 32'h12345678;
      @(posedge clk); #1;
      ack = 1'b0;
      chk("late_ack_req", 32'(bus_req_o), 32'd0);
      chk("late_ack_rw", 32'(MEM_WB_wb_reg_write), 32'd0);
      chk("late_ack_data", MEM_WB_mem_data, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
